// File: rtl/apb_mem_pkg.sv
// rtl/apb_mem_pkg.sv - shared state encoding, size codes and strobe helpers for apb_mem_bridge
package apb_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WR_ISSUE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RESP,
        ST_ERR
    } state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    // Size code for a legal strobe pattern; illegal patterns never reach the memory port
    function automatic logic [1:0] strb_to_len(input logic [3:0] strb);
        case (strb)
            4'b0011, 4'b1100: strb_to_len = LEN_HALF;
            4'b1111:          strb_to_len = LEN_WORD;
            default:          strb_to_len = LEN_BYTE;
        endcase
    endfunction

    // Index of the lowest enabled byte lane (0 when no lane is set)
    function automatic logic [1:0] strb_low_lane(input logic [3:0] strb);
        if (strb[0])      strb_low_lane = 2'd0;
        else if (strb[1]) strb_low_lane = 2'd1;
        else if (strb[2]) strb_low_lane = 2'd2;
        else if (strb[3]) strb_low_lane = 2'd3;
        else              strb_low_lane = 2'd0;
    endfunction

    // Only naturally aligned byte, halfword and word strobes map onto the memory port
    function automatic logic strb_legal(input logic [3:0] strb);
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: strb_legal = 1'b1;
            default:                   strb_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/apb_mem_decode.sv
// rtl/apb_mem_decode.sv - combinational window/alignment/strobe decode of a captured APB request
module apb_mem_decode
    import apb_mem_pkg::*;
#(
    parameter int                        ADDRESS_LENGTH = 32,
    parameter logic [ADDRESS_LENGTH-1:0] MEM_BASE       = '0,
    parameter int                        MEM_SIZE_BYTES = 4096
) (
    input  logic [ADDRESS_LENGTH-1:0] paddr,
    input  logic                      pwrite,
    input  logic [3:0]                pstrb,
    output logic                      err,
    output logic [ADDRESS_LENGTH-1:0] rel_addr,
    output logic [1:0]                lane,
    output logic [1:0]                len
);

    localparam logic [ADDRESS_LENGTH-1:0] WIN_SIZE = ADDRESS_LENGTH'(MEM_SIZE_BYTES);

    logic [ADDRESS_LENGTH-1:0] offset;
    logic                      in_window;

    // Addresses below the base wrap to a huge offset, so one compare covers both window edges
    always_comb begin
        offset    = paddr - MEM_BASE;
        in_window = (offset < WIN_SIZE);
        lane      = pwrite ? strb_low_lane(pstrb) : 2'd0;
        len       = pwrite ? strb_to_len(pstrb) : LEN_WORD;
        rel_addr  = offset + {{(ADDRESS_LENGTH-2){1'b0}}, lane};
        err       = !in_window
                  || (!pwrite && (paddr[1:0] != 2'b00))
                  || (pwrite && !strb_legal(pstrb));
    end

endmodule

// File: rtl/apb_mem_bridge.sv
// rtl/apb_mem_bridge.sv - APB4 completer onto the memory wrapper port; APB_ERR_CNT_EN adds err_count
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int                        DATA_LENGTH    = 32,
    parameter int                        ADDRESS_LENGTH = 32,
    parameter logic [ADDRESS_LENGTH-1:0] MEM_BASE       = '0,
    parameter int                        MEM_SIZE_BYTES = 4096,
    parameter int                        MEM_RD_LATENCY = 1
) (
    input  logic                       from_top_clk,
    input  logic                       preset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [ADDRESS_LENGTH-1:0]  from_top_apb_paddr,
    input  logic [DATA_LENGTH-1:0]     from_top_apb_pwdata,
    input  logic [DATA_LENGTH/8-1:0]   pstrb,
    output logic                       pready,
    output logic [DATA_LENGTH-1:0]     prdata,
    output logic                       pslverr,
    output logic                       to_mem_en,
    output logic                       to_mem_wr_en,
    output logic                       to_mem_rd_en,
    output logic [ADDRESS_LENGTH-1:0]  to_mem_address,
    output logic [DATA_LENGTH-1:0]     to_mem_data_in,
    output logic [1:0]                 to_mem_data_length,
`ifdef APB_ERR_CNT_EN
    output logic [15:0]                err_count,
`endif
    input  logic [DATA_LENGTH-1:0]     from_mem_data_out
);

    localparam logic [3:0] RD_CNT_INIT = 4'(MEM_RD_LATENCY - 1);

    state_t                     state;
    logic [ADDRESS_LENGTH-1:0]  paddr_q;
    logic                       pwrite_q;
    logic [DATA_LENGTH-1:0]     pwdata_q;
    logic [DATA_LENGTH/8-1:0]   pstrb_q;
    logic [3:0]                 rd_cnt;

    logic                       dec_err;
    logic [ADDRESS_LENGTH-1:0]  dec_addr;
    logic [1:0]                 dec_lane;
    logic [1:0]                 dec_len;

    apb_mem_decode #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH),
        .MEM_BASE       (MEM_BASE),
        .MEM_SIZE_BYTES (MEM_SIZE_BYTES)
    ) u_decode (
        .paddr    (paddr_q),
        .pwrite   (pwrite_q),
        .pstrb    (pstrb_q),
        .err      (dec_err),
        .rel_addr (dec_addr),
        .lane     (dec_lane),
        .len      (dec_len)
    );

    // Transfer sequencer; every output is registered and driven from here
    always_ff @(posedge from_top_clk or posedge preset) begin
        if (preset) begin
            state              <= ST_IDLE;
            paddr_q            <= '0;
            pwrite_q           <= 1'b0;
            pwdata_q           <= '0;
            pstrb_q            <= '0;
            rd_cnt             <= '0;
            pready             <= 1'b0;
            prdata             <= '0;
            pslverr            <= 1'b0;
            to_mem_en          <= 1'b0;
            to_mem_wr_en       <= 1'b0;
            to_mem_rd_en       <= 1'b0;
            to_mem_address     <= '0;
            to_mem_data_in     <= '0;
            to_mem_data_length <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        paddr_q  <= from_top_apb_paddr;
                        pwrite_q <= pwrite;
                        pwdata_q <= from_top_apb_pwdata;
                        pstrb_q  <= pstrb;
                        state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (dec_err) begin
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state   <= ST_ERR;
                    end else begin
                        to_mem_address     <= dec_addr;
                        to_mem_data_length <= dec_len;
                        to_mem_en          <= 1'b1;
                        if (pwrite_q) begin
                            to_mem_data_in <= pwdata_q >> {dec_lane, 3'b000};
                            to_mem_wr_en   <= 1'b1;
                            state          <= ST_WR_ISSUE;
                        end else begin
                            to_mem_rd_en <= 1'b1;
                            state        <= ST_RD_ISSUE;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    to_mem_en    <= 1'b0;
                    to_mem_wr_en <= 1'b0;
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else begin
                        pready <= 1'b1;
                        state  <= ST_RESP;
                    end
                end
                ST_RD_ISSUE: begin
                    to_mem_en    <= 1'b0;
                    to_mem_rd_en <= 1'b0;
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else begin
                        rd_cnt <= RD_CNT_INIT;
                        state  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (!psel) begin
                        state <= ST_IDLE;
                    end else if (rd_cnt == 4'd0) begin
                        prdata <= from_mem_data_out;
                        pready <= 1'b1;
                        state  <= ST_RESP;
                    end else begin
                        rd_cnt <= rd_cnt - 4'd1;
                    end
                end
                ST_RESP, ST_ERR: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef APB_ERR_CNT_EN
    // Saturating tally of error responses, one per ERR cycle
    always_ff @(posedge from_top_clk or posedge preset) begin
        if (preset) begin
            err_count <= '0;
        end else if (state == ST_ERR && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
